// File: rtl/record_arbiter.sv
// rtl/record_arbiter.sv - shares the ring buffer write port between LPC records, lost markers and heartbeats
// Dropped LPC records are counted and reported by one marker once space returns.
module record_arbiter #(
   parameter int unsigned HEARTBEAT_CYCLES = 12000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        lpc_valid,
   input  logic [47:0] lpc_record,
   input  logic        buffer_full,
   input  logic        heartbeat_enable,
   output logic        write_clock_enable,
   output logic [47:0] write_data,
   output logic        dropping
);

   localparam int TW = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [TW-1:0] HB_LAST = TW'(HEARTBEAT_CYCLES - 1);

   localparam logic [3:0] TYPE_LOST      = 4'h1;
   localparam logic [3:0] TYPE_HEARTBEAT = 4'h2;

   logic [31:0]   lost_count_q, lost_count_d;
   logic [TW-1:0] hb_timer_q, hb_timer_d;
   logic          hb_pending_q, hb_pending_d;
   logic [31:0]   hb_seq_q, hb_seq_d;
   logic          wce_q, wce_d;
   logic [47:0]   wdata_q, wdata_d;
   logic          dropping_q, dropping_d;
   logic          hb_write;

   always_comb begin
      lost_count_d = lost_count_q;
      hb_timer_d   = hb_timer_q;
      hb_pending_d = hb_pending_q;
      hb_seq_d     = hb_seq_q;
      wce_d        = 1'b0;
      wdata_d      = wdata_q;
      hb_write     = 1'b0;

      // LPC data always wins the cycle; once anything is lost, every record is dropped until the marker goes out.
      if (lpc_valid) begin
         if ((lost_count_q == 32'd0) && !buffer_full) begin
            wce_d   = 1'b1;
            wdata_d = lpc_record;
         end else if (lost_count_q != 32'hFFFF_FFFF) begin
            lost_count_d = lost_count_q + 32'd1;
         end
      end else if (!buffer_full) begin
         if (lost_count_q != 32'd0) begin
            wce_d        = 1'b1;
            wdata_d      = {lost_count_q, 8'h00, TYPE_LOST, 4'h0};
            lost_count_d = 32'd0;
         end else if (hb_pending_q) begin
            wce_d    = 1'b1;
            wdata_d  = {hb_seq_q, 8'h00, TYPE_HEARTBEAT, 4'h0};
            hb_seq_d = hb_seq_q + 32'd1;
            hb_write = 1'b1;
         end
      end

      // An expiry coinciding with a heartbeat write re-arms pending rather than losing the tick.
      if (!heartbeat_enable) begin
         hb_timer_d   = '0;
         hb_pending_d = 1'b0;
      end else if (hb_timer_q == HB_LAST) begin
         hb_timer_d   = '0;
         hb_pending_d = 1'b1;
      end else begin
         hb_timer_d = hb_timer_q + TW'(1);
         if (hb_write) begin
            hb_pending_d = 1'b0;
         end
      end

      dropping_d = (lost_count_d != 32'd0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lost_count_q <= 32'd0;
         hb_timer_q   <= '0;
         hb_pending_q <= 1'b0;
         hb_seq_q     <= 32'd0;
         wce_q        <= 1'b0;
         wdata_q      <= 48'd0;
         dropping_q   <= 1'b0;
      end else begin
         lost_count_q <= lost_count_d;
         hb_timer_q   <= hb_timer_d;
         hb_pending_q <= hb_pending_d;
         hb_seq_q     <= hb_seq_d;
         wce_q        <= wce_d;
         wdata_q      <= wdata_d;
         dropping_q   <= dropping_d;
      end
   end

   assign write_clock_enable = wce_q;
   assign write_data         = wdata_q;
   assign dropping           = dropping_q;

endmodule

// File: tb/tb_record_arbiter.sv
// tb/tb_record_arbiter.sv - directed and randomized bench for record_arbiter
// Expected outputs come from a cycle-level model of the write priority rules.
module tb_record_arbiter;

   localparam int HB = 8;

   logic        clock;
   logic        reset;
   logic        lpc_valid;
   logic [47:0] lpc_record;
   logic        buffer_full;
   logic        heartbeat_enable;
   logic        write_clock_enable;
   logic [47:0] write_data;
   logic        dropping;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_lost;
   int          m_timer;
   bit          m_pend;
   logic [31:0] m_seq;
   bit          e_wce;
   logic [47:0] e_wdata;
   bit          e_drop;
   bit          prev_lv;

   record_arbiter #(.HEARTBEAT_CYCLES(HB)) dut (
      .clock              (clock),
      .reset              (reset),
      .lpc_valid          (lpc_valid),
      .lpc_record         (lpc_record),
      .buffer_full        (buffer_full),
      .heartbeat_enable   (heartbeat_enable),
      .write_clock_enable (write_clock_enable),
      .write_data         (write_data),
      .dropping           (dropping)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lost  = 32'd0;
      m_timer = 0;
      m_pend  = 1'b0;
      m_seq   = 32'd0;
      e_wce   = 1'b0;
      e_wdata = 48'd0;
      e_drop  = 1'b0;
      prev_lv = 1'b0;
   endtask

   task automatic model_step(input bit lv, input logic [47:0] rec, input bit bf, input bit hbe);
      bit hb_wrote;
      hb_wrote = 1'b0;
      e_wce    = 1'b0;
      if (lv && m_lost == 0 && !bf) begin
         e_wce   = 1'b1;
         e_wdata = rec;
      end else if (lv) begin
         if (m_lost != 32'hFFFF_FFFF) m_lost = m_lost + 1;
      end else if (m_lost != 0 && !bf) begin
         e_wce   = 1'b1;
         e_wdata = {m_lost, 16'h0010};
         m_lost  = 0;
      end else if (m_pend && !bf) begin
         e_wce    = 1'b1;
         e_wdata  = {m_seq, 16'h0020};
         m_seq    = m_seq + 1;
         hb_wrote = 1'b1;
      end
      if (!hbe) begin
         m_timer = 0;
         m_pend  = 1'b0;
      end else if (m_timer == HB - 1) begin
         m_timer = 0;
         m_pend  = 1'b1;
      end else begin
         m_timer++;
         if (hb_wrote) m_pend = 1'b0;
      end
      e_drop = (m_lost != 0);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit lv, input logic [47:0] rec, input bit bf, input bit hbe);
      lpc_valid        = lv;
      lpc_record       = rec;
      buffer_full      = bf;
      heartbeat_enable = hbe;
      model_step(lv, rec, bf, hbe);
      prev_lv = lv;
      @(posedge clock);
      #1;
      chk("wce", 48'(write_clock_enable), 48'(e_wce));
      chk("dropping", 48'(dropping), 48'(e_drop));
      if (e_wce) chk("wdata", write_data, e_wdata);
      @(negedge clock);
   endtask

   task automatic do_reset(input bit hbe);
      reset            = 1'b0;
      lpc_valid        = 1'b0;
      lpc_record       = 48'd0;
      buffer_full      = 1'b0;
      heartbeat_enable = hbe;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      chk("rst_wce", 48'(write_clock_enable), 48'd0);
      chk("rst_wdata", write_data, 48'd0);
      chk("rst_drop", 48'(dropping), 48'd0);
      reset = 1'b1;
   endtask

   function automatic logic [47:0] rand_rec();
      return {32'($urandom), 8'($urandom), 4'h0, 4'($urandom)};
   endfunction

   initial begin
      int writes;
      bit lv;
      bit hbe;
      reset = 1'b0;
      @(negedge clock);

      // Pass-through
      do_reset(1'b0);
      cycle(1, 48'h0000_0080_A501, 0, 0);
      chk("pass_wce", 48'(write_clock_enable), 48'd1);
      chk("pass_data", write_data, 48'h0000_0080_A501);
      chk("pass_drop", 48'(dropping), 48'd0);
      cycle(0, 48'd0, 0, 0);

      // Drop three records while full, then marker
      writes = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1, rand_rec(), 1, 0);
         writes += int'(write_clock_enable);
         cycle(0, 48'd0, 1, 0);
         writes += int'(write_clock_enable);
      end
      chk("full_nowrite", 48'(writes), 48'd0);
      chk("full_drop", 48'(dropping), 48'd1);
      cycle(0, 48'd0, 0, 0);
      chk("marker3", write_data, 48'h0000_0003_0010);
      chk("marker3_wce", 48'(write_clock_enable), 48'd1);
      chk("marker3_drop", 48'(dropping), 48'd0);
      cycle(1, 48'h1234_5678_9A0B, 0, 0);
      chk("after_marker", write_data, 48'h1234_5678_9A0B);
      cycle(0, 48'd0, 0, 0);

      // Ordering: space returns on the same cycle as an LPC record
      cycle(1, rand_rec(), 1, 0);
      cycle(0, 48'd0, 1, 0);
      cycle(1, rand_rec(), 1, 0);
      cycle(0, 48'd0, 1, 0);
      cycle(1, rand_rec(), 0, 0);
      chk("ord_nowrite", 48'(write_clock_enable), 48'd0);
      chk("ord_drop", 48'(dropping), 48'd1);
      cycle(0, 48'd0, 0, 0);
      chk("ord_marker", write_data, 48'h0000_0003_0010);

      // Heartbeat cadence from reset release
      do_reset(1'b1);
      for (int k = 1; k <= 17; k++) begin
         cycle(0, 48'd0, 0, 1);
         if (k == 9) chk("hb0", write_data, 48'h0000_0000_0020);
         if (k == 9) chk("hb0_wce", 48'(write_clock_enable), 48'd1);
         if (k == 17) chk("hb1", write_data, 48'h0000_0001_0020);
      end

      // Two expiries while full merge into one heartbeat
      do_reset(1'b1);
      for (int k = 0; k < 18; k++) cycle(0, 48'd0, 1, 1);
      writes = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(0, 48'd0, 0, 1);
         writes += int'(write_clock_enable);
      end
      chk("hb_merge", 48'(writes), 48'd1);

      // Saturation
      do_reset(1'b0);
      force dut.lost_count_q = 32'hFFFF_FFFE;
      m_lost = 32'hFFFF_FFFE;
      cycle(0, 48'd0, 1, 0);
      release dut.lost_count_q;
      for (int i = 0; i < 3; i++) begin
         cycle(1, rand_rec(), 1, 0);
         cycle(0, 48'd0, 1, 0);
      end
      cycle(0, 48'd0, 0, 0);
      chk("sat_marker", write_data, 48'hFFFF_FFFF_0010);

      // Reset while dropping
      cycle(1, rand_rec(), 1, 0);
      chk("pre_rst_drop", 48'(dropping), 48'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_drop", 48'(dropping), 48'd0);
      chk("async_wce", 48'(write_clock_enable), 48'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      writes = 0;
      for (int k = 0; k < 6; k++) begin
         cycle(0, 48'd0, 0, 0);
         writes += int'(write_clock_enable);
      end
      chk("no_marker_after_rst", 48'(writes), 48'd0);

      // Randomized traffic against the model
      do_reset(1'b1);
      hbe = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 49) == 0) hbe = ~hbe;
         lv = !prev_lv && ($urandom_range(0, 2) == 0);
         cycle(lv, rand_rec(), ($urandom_range(0, 3) == 0), hbe);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
